// File: rtl/j1_timer_bank.sv
// j1_timer_bank: NCH independent prescaled down-counters on the J1 I/O bus.
// Each channel has COUNT, RELOAD, CTRL and STATUS registers. The channel
// index is io_addr[CHB+1:2] and the register is io_addr[1:0]. Expiry sets
// a sticky pending flag, which is cleared by writing 1. irq is the registered
// OR of (pending & ien) over all channels.
module j1_timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int CHB   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           io_sel,
  input  logic           io_wr,
  input  logic           io_rd,
  input  logic [CHB+1:0] io_addr,
  input  logic [15:0]    io_dout,
  output logic [15:0]    io_din,
  output logic           irq
);

  // Per-channel state
  logic [WIDTH-1:0] count_r    [NCH];
  logic [WIDTH-1:0] reload_r   [NCH];
  logic [7:0]       prescale_r [NCH];
  logic [7:0]       pre_r      [NCH];
  logic [NCH-1:0]   en_r;
  logic [NCH-1:0]   periodic_r;
  logic [NCH-1:0]   ien_r;
  logic [NCH-1:0]   pend_r;
  logic             irq_r;

  // Decode and event signals
  logic [CHB-1:0]   ch_idx_s;
  logic [1:0]       reg_s;
  logic             wr_s;
  logic [NCH-1:0]   ch_hit_s;
  logic [NCH-1:0]   wr_count_s;
  logic [NCH-1:0]   wr_reload_s;
  logic [NCH-1:0]   wr_ctrl_s;
  logic [NCH-1:0]   wr_clr_s;
  logic [NCH-1:0]   tick_s;
  logic [NCH-1:0]   expire_s;
  logic [NCH-1:0]   pre_run_s;
  logic [15:0]      chan_rd_s  [NCH];
  logic [15:0]      rd_s;

  // io_rd only exists for bus symmetry; reads have no side effects, and
  // CTRL bits [7:3] of the write data are unused.
  logic             unused_s;
  assign unused_s = ^{io_rd, io_dout};

  assign ch_idx_s = io_addr[CHB+1:2];
  assign reg_s    = io_addr[1:0];
  assign wr_s     = io_sel & io_wr;

  // Address decode, write strobes, prescaler ticks and expiry detection
  always_comb begin
    ch_hit_s    = {NCH{1'b0}};
    wr_count_s  = {NCH{1'b0}};
    wr_reload_s = {NCH{1'b0}};
    wr_ctrl_s   = {NCH{1'b0}};
    wr_clr_s    = {NCH{1'b0}};
    tick_s      = {NCH{1'b0}};
    expire_s    = {NCH{1'b0}};
    pre_run_s   = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      // Indices >= NCH match no channel, so they read 0 and drop writes
      ch_hit_s[i]    = (ch_idx_s == CHB'(i));
      wr_count_s[i]  = wr_s & ch_hit_s[i] & (reg_s == 2'd0);
      wr_reload_s[i] = wr_s & ch_hit_s[i] & (reg_s == 2'd1);
      wr_ctrl_s[i]   = wr_s & ch_hit_s[i] & (reg_s == 2'd2);
      wr_clr_s[i]    = wr_s & ch_hit_s[i] & (reg_s == 2'd3) & io_dout[0];
      tick_s[i]      = en_r[i] & (pre_r[i] == prescale_r[i]);
      // A COUNT write in the same cycle swallows the tick entirely
      expire_s[i]    = tick_s[i] & ~wr_count_s[i] & (count_r[i] == {WIDTH{1'b0}});
      // Prescaler advances only while enabled, not ticking, and not being
      // disabled by a CTRL write; enabling from 0 therefore restarts at 0
      pre_run_s[i]   = en_r[i] & ~tick_s[i] & ~(wr_ctrl_s[i] & ~io_dout[0]);
    end
  end

  // Channel registers: counters, prescalers, control, pending flags and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        count_r[i]    <= {WIDTH{1'b0}};
        reload_r[i]   <= {WIDTH{1'b0}};
        prescale_r[i] <= 8'd0;
        pre_r[i]      <= 8'd0;
      end
      en_r       <= {NCH{1'b0}};
      periodic_r <= {NCH{1'b0}};
      ien_r      <= {NCH{1'b0}};
      pend_r     <= {NCH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_count_s[i]) begin
          count_r[i] <= io_dout[WIDTH-1:0];
        end else if (tick_s[i]) begin
          if (count_r[i] != {WIDTH{1'b0}}) begin
            count_r[i] <= count_r[i] - WIDTH'(1'b1);
          end else if (periodic_r[i]) begin
            count_r[i] <= reload_r[i];
          end
        end

        if (wr_reload_s[i]) begin
          reload_r[i] <= io_dout[WIDTH-1:0];
        end

        // A CTRL write takes priority over the one-shot auto-disable
        if (wr_ctrl_s[i]) begin
          en_r[i]       <= io_dout[0];
          periodic_r[i] <= io_dout[1];
          ien_r[i]      <= io_dout[2];
          prescale_r[i] <= io_dout[15:8];
        end else if (expire_s[i] & ~periodic_r[i]) begin
          en_r[i] <= 1'b0;
        end

        pre_r[i] <= pre_run_s[i] ? (pre_r[i] + 8'd1) : 8'd0;

        // Set beats clear when both land in the same cycle
        if (expire_s[i]) begin
          pend_r[i] <= 1'b1;
        end else if (wr_clr_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
      irq_r <= |(pend_r & ien_r);
    end
  end

  // Per-channel read values, zero-extended to 16 bits
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chan_rd_s[i] = 16'd0;
      case (reg_s)
        2'd0:    chan_rd_s[i][WIDTH-1:0] = count_r[i];
        2'd1:    chan_rd_s[i][WIDTH-1:0] = reload_r[i];
        2'd2:    chan_rd_s[i] = {prescale_r[i], 5'd0, ien_r[i], periodic_r[i], en_r[i]};
        2'd3:    chan_rd_s[i] = {15'd0, pend_r[i]};
        default: chan_rd_s[i] = 16'd0;
      endcase
    end
  end

  // Read mux: OR of the selected channel's value (0 for an unmapped index)
  always_comb begin
    rd_s = 16'd0;
    for (int i = 0; i < NCH; i++) begin
      rd_s = rd_s | (ch_hit_s[i] ? chan_rd_s[i] : 16'd0);
    end
  end

  assign io_din = io_sel ? rd_s : 16'd0;
  assign irq    = irq_r;

endmodule
